// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V core: operand forwarding, load-use
// and control-flow hazards, multi-cycle data-memory sequencing and perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 MemAccessM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemReqM,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_t;

  mem_state_t           state_reg, state_next;
  logic [WCW-1:0]       wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0] stall_cycles_reg, stall_cycles_next;
  logic [CNT_WIDTH-1:0] flush_count_reg, flush_count_next;

  logic       mem_busy;
  logic       mem_req;
  logic       lw_stall;
  logic [4:0] rs_e [2];
  logic [1:0] fwd_sel [2];

  // Forwarding: M result is newer than W, so it wins when both match.
  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m, hit_w;
      assign hit_m = RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]);
      assign hit_w = RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi]);
      assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
    end
  endgenerate

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory sequencer next state and the busy/request decode of the current state.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_busy      = 1'b0;
    mem_req       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        mem_req  = MemAccessM;
        mem_busy = MemAccessM && !MemReadyM;
        if (MemAccessM && !MemReadyM) begin
          state_next    = ST_WAIT;
          wait_cnt_next = '0;
        end
      end
      ST_WAIT: begin
        mem_req  = 1'b1;
        mem_busy = !MemReadyM;
        if (MemReadyM) begin
          state_next = ST_IDLE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next = ST_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_ERR: begin
        mem_busy = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pipeline control with memory busy > taken branch > load-use priority.
  always_comb begin
    ForwardAE = fwd_sel[0];
    ForwardBE = fwd_sel[1];
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemReqM   = mem_req;
    if (rst) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      MemReqM   = 1'b0;
    end else if (mem_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    flush_count_next  = flush_count_reg;
    if ((StallF || StallD || StallE || StallM) && (stall_cycles_reg != '1)) begin
      stall_cycles_next = stall_cycles_reg + 1'b1;
    end
    if (PCSrcE && !mem_busy && (flush_count_reg != '1)) begin
      flush_count_next = flush_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      wait_cnt_reg     <= '0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
    end
  end

  assign MemErr      = (state_reg == ST_ERR);
  assign StallCycles = stall_cycles_reg;
  assign FlushCount  = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a streak-count model
// of the memory access and a rule-level model of the pipeline controls.
module tb_hazard_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_m, reg_write_w;
  logic [1:0] result_src_e;
  logic pcsrc_e, mem_access, mem_ready;
  logic [1:0] forward_ae, forward_be;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic mem_req, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: consecutive not-ready cycles of the pending access, error flag, counters.
  int m_streak = 0;
  bit m_err    = 0;
  int m_stalls = 0;
  int m_flush  = 0;
  int req_seen = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e),
    .RdE(rd_e), .RdM(rd_m), .RdW(rd_w),
    .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .ResultSrcE(result_src_e), .PCSrcE(pcsrc_e),
    .MemAccessM(mem_access), .MemReadyM(mem_ready),
    .ForwardAE(forward_ae), .ForwardBE(forward_be),
    .StallF(stall_f), .StallD(stall_d), .StallE(stall_e), .StallM(stall_m),
    .FlushD(flush_d), .FlushE(flush_e), .FlushW(flush_w),
    .MemReqM(mem_req), .MemErr(mem_err),
    .StallCycles(stall_cycles), .FlushCount(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic cycle();
    logic [1:0] efa, efb;
    logic [3:0] est;
    logic [2:0] efl;
    logic ereq;
    bit busy, lw;
    @(negedge clk);
    busy = m_err || ((m_streak > 0) ? !mem_ready : (mem_access && !mem_ready));
    lw   = (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
    efa  = fwd_model(rs1_e);
    efb  = fwd_model(rs2_e);
    ereq = m_err ? 1'b0 : ((m_streak > 0) ? 1'b1 : mem_access);
    est  = 4'b0000;
    efl  = 3'b000;
    if (rst) begin
      efl = 3'b111; ereq = 1'b0; efa = 2'b00; efb = 2'b00;
    end else if (busy) begin
      est = 4'b1111; efl = 3'b001;
    end else if (pcsrc_e) begin
      efl = 3'b110;
    end else if (lw) begin
      est = 4'b1100; efl = 3'b010;
    end
    check("fwd_a", 32'(forward_ae), 32'(efa));
    check("fwd_b", 32'(forward_be), 32'(efb));
    check("stall_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(est));
    check("flush_dew", 32'({flush_d, flush_e, flush_w}), 32'(efl));
    check("mem_req", 32'(mem_req), 32'(ereq));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    check("flush_count", 32'(flush_count), 32'(m_flush));
    if (mem_req === 1'b1) req_seen++;
    @(posedge clk);
    if (rst) begin
      m_streak = 0; m_err = 0; m_stalls = 0; m_flush = 0;
    end else begin
      if (est != 0 && m_stalls < CMAX) m_stalls++;
      if (pcsrc_e && !busy && m_flush < CMAX) m_flush++;
      if (!m_err && (m_streak > 0 || mem_access)) begin
        if (mem_ready) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak == T + 1) m_err = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; result_src_e = 2'b00;
    pcsrc_e = 0; mem_access = 0; mem_ready = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_inputs();
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Forwarding priority
    rd_m = 5; rd_w = 5; rs1_e = 5; reg_write_m = 1; reg_write_w = 1;
    cycle();
    check("fwd_m_prio", 32'(forward_ae), 32'h2);
    reg_write_m = 0;
    cycle();
    check("fwd_w", 32'(forward_ae), 32'h1);
    rs1_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1;
    cycle();
    check("fwd_x0", 32'(forward_ae), 32'h0);

    // Load-use, then load-use hidden by a taken branch
    idle_inputs();
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    cycle();
    check("lw_stall_cnt", 32'(stall_cycles), 32'h1);
    pcsrc_e = 1;
    cycle();
    check("lw_branch_flush", 32'(flush_count), 32'h1);
    check("lw_branch_nostall", 32'(stall_cycles), 32'h1);

    // Three not-ready cycles then ready
    do_reset(1);
    req_seen = 0;
    mem_access = 1;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    mem_access = 0; mem_ready = 0;
    cycle();
    check("wait_stalls", 32'(stall_cycles), 32'h3);
    check("wait_req_cycles", 32'(req_seen), 32'h4);

    // Timeout into ERR, ready pulse ignored, reset recovers
    do_reset(1);
    mem_access = 1;
    repeat (4) cycle();
    check("err_not_yet", 32'(mem_err), 32'h0);
    cycle();
    check("err_cycle6", 32'(mem_err), 32'h1);
    mem_access = 0;
    cycle();
    mem_ready = 1;
    cycle();
    mem_ready = 0;
    check("err_sticky", 32'(mem_err), 32'h1);
    do_reset(1);
    check("err_cleared", 32'(mem_err), 32'h0);

    // Ready exactly at the last WAIT count completes normally
    mem_access = 1;
    repeat (4) cycle();
    mem_ready = 1;
    cycle();
    mem_access = 0; mem_ready = 0;
    cycle();
    check("boundary_no_err", 32'(mem_err), 32'h0);

    // Memory stall together with a taken branch
    do_reset(1);
    mem_access = 1; pcsrc_e = 1;
    repeat (2) cycle();
    check("busy_branch_noflush", 32'(flush_count), 32'h0);
    mem_ready = 1;
    cycle();
    check("branch_after_busy", 32'(flush_count), 32'h1);
    idle_inputs();

    // Counter saturation
    do_reset(1);
    result_src_e = 2'b01; rd_e = 3; rs1_d = 3;
    repeat (20) cycle();
    check("stall_saturate", 32'(stall_cycles), 32'(CMAX));

    // Random traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      rs1_d        = 5'($urandom_range(0, 3));
      rs2_d        = 5'($urandom_range(0, 3));
      rs1_e        = 5'($urandom_range(0, 3));
      rs2_e        = 5'($urandom_range(0, 3));
      rd_e         = 5'($urandom_range(0, 3));
      rd_m         = 5'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 3));
      reg_write_m  = 1'($urandom);
      reg_write_w  = 1'($urandom);
      result_src_e = 2'($urandom);
      pcsrc_e      = ($urandom_range(0, 5) == 0);
      mem_access   = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
